// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS execute-stage ALU: operation codes,
// FSM state encoding and iteration constants.
package alu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ITER_COUNT = 32;

    // Counter values: the last iteration step and the "engine idle" value.
    localparam logic [5:0] ITER_LAST = 6'(ITER_COUNT - 1);
    localparam logic [5:0] ITER_DONE = 6'(ITER_COUNT);

    // alu_control codes produced by the ALU control decoder.
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_NOR    = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SLL    = 5'd6;
    localparam logic [4:0] ALU_SRL    = 5'd7;
    localparam logic [4:0] ALU_SRA    = 5'd8;
    localparam logic [4:0] ALU_SLT    = 5'd9;
    localparam logic [4:0] ALU_MULT   = 5'd10;
    localparam logic [4:0] ALU_DIV    = 5'd11;
    localparam logic [4:0] ALU_PASSA  = 5'd12;
    localparam logic [4:0] ALU_LEZ    = 5'd13;
    localparam logic [4:0] ALU_GTZ    = 5'd14;
    localparam logic [4:0] ALU_GEZ    = 5'd15;
    localparam logic [4:0] ALU_RSV16  = 5'd16;  // unused code, passes a through
    localparam logic [4:0] ALU_LUI    = 5'd17;
    localparam logic [4:0] ALU_CMP18  = 5'd18;  // branch compare, subtract
    localparam logic [4:0] ALU_CMP19  = 5'd19;  // branch compare, subtract

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } alu_state_e;

    function automatic logic is_muldiv(input logic [4:0] code);
        return (code == ALU_MULT) || (code == ALU_DIV);
    endfunction

    // Codes whose zero flag is bit 0 of the result instead of result==0.
    function automatic logic zero_from_bit0(input logic [4:0] code);
        return (code == ALU_SLT) || (code == ALU_LEZ) ||
               (code == ALU_GTZ) || (code == ALU_GEZ);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative signed multiply / divide engine. Works on operand magnitudes,
// one bit per cycle for ITER_COUNT cycles, and presents sign-corrected
// hi/lo combinationally once the iterations are finished.
module alu_muldiv_iter
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            op_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    // Counter sits at ITER_DONE when no iteration is pending.
    logic [5:0]      cnt_q;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;   // partial product high / remainder
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;   // multiplier shifting out / quotient shifting in
    logic [XLEN-1:0] mag_b_q;              // |b|: multiplicand or divisor
    logic [XLEN-1:0] a_q;                  // original dividend for divide-by-zero
    logic            op_div_q;
    logic            neg_q;                // sign of product / quotient
    logic            sign_a_q;             // sign of remainder
    logic            b_zero_q;

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_signed;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? (~x + 1'b1) : x;
    endfunction

    // One iteration step: shift-add multiply or restoring divide.
    always_comb begin
        sum      = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mag_b_q : '0)};
        shifted  = {acc_hi_q, acc_lo_q[XLEN-1]};
        trial    = shifted - {1'b0, mag_b_q};
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        if (op_div_q) begin
            if (!trial[XLEN]) begin
                acc_hi_d = trial[XLEN-1:0];
                acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
            end else begin
                acc_hi_d = shifted[XLEN-1:0];
                acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_hi_d = sum[XLEN:1];
            acc_lo_d = {sum[0], acc_lo_q[XLEN-1:1]};
        end
    end

    // Load magnitudes on start, otherwise step until the count is exhausted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= ITER_DONE;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mag_b_q  <= '0;
            a_q      <= '0;
            op_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            b_zero_q <= 1'b0;
        end else if (start_i) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= mag(a_i);
            mag_b_q  <= mag(b_i);
            a_q      <= a_i;
            op_div_q <= op_div_i;
            neg_q    <= a_i[XLEN-1] ^ b_i[XLEN-1];
            sign_a_q <= a_i[XLEN-1];
            b_zero_q <= (b_i == '0);
        end else if (cnt_q != ITER_DONE) begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + 6'd1;
        end
    end

    // The final iteration happens at the coming edge.
    assign done_o = (cnt_q == ITER_LAST);

    // Sign fix-up of the finished magnitudes.
    always_comb begin
        prod        = {acc_hi_q, acc_lo_q};
        prod_signed = neg_q ? (~prod + 1'b1) : prod;
        hi_o        = prod_signed[2*XLEN-1:XLEN];
        lo_o        = prod_signed[XLEN-1:0];
        if (op_div_q) begin
            if (b_zero_q) begin
                lo_o = '1;
                hi_o = a_q;
            end else begin
                lo_o = neg_q    ? (~acc_lo_q + 1'b1) : acc_lo_q;
                hi_o = sign_a_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
            end
        end
    end

endmodule

// File: rtl/mips_alu.sv
// MIPS execute-stage ALU: single-cycle logic/arith/shift/compare datapath,
// registered result and zero flag, and a three-state FSM sequencing the
// iterative MULT/DIV engine that owns the HI/LO results.
//
// Handshake: a request is accepted on a rising edge where in_valid and
// in_ready are both high; requests while in_ready is low are dropped.
// out_valid is a one-cycle pulse per completed operation, with result and
// zero valid in that cycle and held afterwards.
module mips_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output alu_state_e       dbg_state
);

    alu_state_e       state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] alu_res_d;
    logic             alu_zero_d;
    logic [4:0]       shamt;
    logic             accept;
    logic             start;
    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign start    = accept && is_muldiv(alu_control);
    assign shamt    = a[4:0];

    // Single-cycle datapath and its zero flag.
    always_comb begin
        alu_res_d = a;
        case (alu_control)
            ALU_ADD:                        alu_res_d = a + b;
            ALU_SUB, ALU_CMP18, ALU_CMP19:  alu_res_d = a - b;
            ALU_AND:                        alu_res_d = a & b;
            ALU_OR:                         alu_res_d = a | b;
            ALU_NOR:                        alu_res_d = ~(a | b);
            ALU_XOR:                        alu_res_d = a ^ b;
            ALU_SLL:                        alu_res_d = b << shamt;
            ALU_SRL:                        alu_res_d = b >> shamt;
            ALU_SRA:                        alu_res_d = $signed(b) >>> shamt;
            ALU_SLT:   alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_PASSA:                      alu_res_d = a;
            ALU_LEZ:   alu_res_d = {{(WIDTH-1){1'b0}}, (a[WIDTH-1] || (a == '0))};
            ALU_GTZ:   alu_res_d = {{(WIDTH-1){1'b0}}, (!a[WIDTH-1] && (a != '0))};
            ALU_GEZ:   alu_res_d = {{(WIDTH-1){1'b0}}, !a[WIDTH-1]};
            ALU_LUI:                        alu_res_d = {b[WIDTH-17:0], 16'h0000};
            default:                        alu_res_d = a;
        endcase
        alu_zero_d = zero_from_bit0(alu_control) ? alu_res_d[0] : (alu_res_d == '0);
    end

    alu_muldiv_iter u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start),
        .op_div_i (alu_control == ALU_DIV),
        .a_i      (a),
        .b_i      (b),
        .done_o   (eng_done),
        .hi_o     (eng_hi),
        .lo_o     (eng_lo)
    );

    // Control FSM with registered result, zero, out_valid and HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ITER;
                    end else if (accept) begin
                        result_q    <= alu_res_d;
                        zero_q      <= alu_zero_d;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ITER: begin
                    if (eng_done) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_q        <= eng_hi;
                    lo_q        <= eng_lo;
                    result_q    <= eng_lo;
                    zero_q      <= (eng_lo == '0);
                    out_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_alu.sv
// Testbench for mips_alu: directed cases plus randomized operations, with
// expected responses queued at accept time and compared by a monitor.
module tb_mips_alu;
    import alu_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   alu_control;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    alu_state_e   dbg_state;

    always #5 clk = ~clk;

    mips_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .result      (result),
        .zero        (zero),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           fails  = 0;
    logic [W-1:0] exp_res_q[$];
    logic         exp_zero_q[$];
    logic [W-1:0] exp_hi_q[$];
    logic [W-1:0] exp_lo_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {zero, result} for single-cycle codes.
    function automatic logic [W:0] ref_single(input logic [4:0] code, input logic [W-1:0] x, input logic [W-1:0] y);
        int           sx;
        int           sy;
        int           sh;
        logic [W-1:0] r;
        logic         z;
        sx = x;
        sy = y;
        sh = int'(x[4:0]);
        case (int'(code))
            0:              r = x + y;
            1, 18, 19:      r = x - y;
            2:              r = x & y;
            3:              r = x | y;
            4:              r = ~(x | y);
            5:              r = x ^ y;
            6:              r = y << sh;
            7:              r = y >> sh;
            8:              r = sy >>> sh;
            9:              r = (sx < sy) ? 1 : 0;
            13:             r = (sx <= 0) ? 1 : 0;
            14:             r = (sx > 0) ? 1 : 0;
            15:             r = (sx >= 0) ? 1 : 0;
            17:             r = y * 32'd65536;
            default:        r = x;
        endcase
        if (code == 5'd9 || code == 5'd13 || code == 5'd14 || code == 5'd15) z = r[0];
        else z = (r == 0);
        return {z, r};
    endfunction

    // Returns {hi, lo} for MULT (10) and DIV (11).
    function automatic logic [2*W-1:0] ref_muldiv(input logic [4:0] code, input logic [W-1:0] x, input logic [W-1:0] y);
        int     sx;
        int     sy;
        int     q;
        int     r;
        longint p;
        sx = x;
        sy = y;
        if (code == 5'd10) begin
            p = longint'(sx) * longint'(sy);
            return p;
        end
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
    endfunction

    // ---------------- driver ----------------
    // Waits for in_ready, presents one request for one edge, queues the
    // expected response. ov_acc reports out_valid in the accepting cycle.
    task automatic issue(input logic [4:0] code, input logic [W-1:0] x, input logic [W-1:0] y, output logic ov_acc);
        int             guard;
        logic [W:0]     s;
        logic [2*W-1:0] hl;
        guard = 0;
        ov_acc = 1'b0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("issue_wait_ready", in_ready, 1);
            return;
        end
        in_valid    = 1'b1;
        alu_control = code;
        a           = x;
        b           = y;
        ov_acc      = out_valid;
        @(posedge clk);
        if (code == 5'd10 || code == 5'd11) begin
            hl   = ref_muldiv(code, x, y);
            m_hi = hl[2*W-1:W];
            m_lo = hl[W-1:0];
            exp_res_q.push_back(m_lo);
            exp_zero_q.push_back(m_lo == 0);
        end else begin
            s = ref_single(code, x, y);
            exp_res_q.push_back(s[W-1:0]);
            exp_zero_q.push_back(s[W]);
        end
        exp_hi_q.push_back(m_hi);
        exp_lo_q.push_back(m_lo);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_res_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", exp_res_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_res_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out_valid: got result 0x%0h, expected no output", result);
            end else begin
                check("result", result, exp_res_q.pop_front());
                check("zero", zero, exp_zero_q.pop_front());
                check("hi", hi, exp_hi_q.pop_front());
                check("lo", lo, exp_lo_q.pop_front());
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic ov;
        int   low_cnt;
        int   busy_cnt;
        logic [4:0] code;

        reset       = 1'b1;
        in_valid    = 1'b0;
        alu_control = '0;
        a           = '0;
        b           = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_zero", zero, 0);
        check("rst_result", result, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // Basic arithmetic and compare, back to back.
        issue(5'd0, 32'h5, 32'hFFFF_FFFB, ov);
        issue(5'd9, 32'h5, 32'hFFFF_FFFB, ov);
        issue(5'd1, 32'h5, 32'hFFFF_FFFB, ov);
        // Shifts and LUI.
        issue(5'd6, 32'h4, 32'h8000_0001, ov);
        issue(5'd7, 32'h4, 32'h8000_0001, ov);
        issue(5'd8, 32'h4, 32'h8000_0001, ov);
        issue(5'd17, 32'h0, 32'h1234, ov);
        drain();

        // MULT timing with a request held while busy (must be dropped).
        issue(5'd10, 32'hFFFF_FFFD, 32'h7, ov);
        in_valid    = 1'b1;
        alu_control = 5'd0;
        a           = 32'h1;
        b           = 32'h2;
        low_cnt  = 0;
        busy_cnt = 0;
        @(negedge clk);
        while (!in_ready && low_cnt < 100) begin
            low_cnt++;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("mult_ready_low_cycles", low_cnt, 33);
        check("mult_busy_cycles", busy_cnt, 33);
        check("mult_done_out_valid", out_valid, 1);
        check("mult_done_busy", busy, 0);
        drain();

        // DIV corner cases.
        issue(5'd11, 32'hFFFF_FFF9, 32'h2, ov);
        issue(5'd11, 32'h9, 32'h0, ov);
        issue(5'd11, 32'h8000_0000, 32'hFFFF_FFFF, ov);
        drain();

        // Reset in the middle of a MULT.
        issue(5'd10, 32'h0123_4567, 32'hFFFF_FF9D, ov);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_res_q.delete();
        exp_zero_q.delete();
        exp_hi_q.delete();
        exp_lo_q.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_state", dbg_state, ST_IDLE);
        repeat (40) @(negedge clk);
        issue(5'd0, 32'h11, 32'h22, ov);
        drain();

        // ADD stream, MULT, then ADD accepted on the MULT completion cycle.
        for (int i = 0; i < 8; i++) begin
            issue(5'd0, $urandom, $urandom, ov);
            check("stream_out_valid", out_valid, 1);
        end
        issue(5'd10, $urandom, $urandom, ov);
        issue(5'd0, $urandom, $urandom, ov);
        check("add_on_mult_done", ov, 1);
        check("add_after_mult_out_valid", out_valid, 1);
        drain();

        // Randomized operations with occasional idle gaps.
        for (int i = 0; i < 150; i++) begin
            code = 5'($urandom_range(0, 19));
            if ((code == 5'd10 || code == 5'd11) && $urandom_range(0, 2) != 0) code = 5'd0;
            issue(code, pick_operand(), pick_operand(), ov);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
